// File: rtl/cpu_pkg.sv
// Shared constants for the five-stage core: next-PC opcodes, reset PC and the nop encoding.
// Also provides the branch-offset helper used by next-PC selection.
package cpu_pkg;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_CBL = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // Word offset of a branch: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection and fault detection for the fetch stage.
// Control inputs come from the instruction in D and are ignored while D is empty.
module npc_calc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] d_pc_i,
    input  logic        d_valid_i,
    input  logic [2:0]  npc_op_i,
    input  logic        cmp_true_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] reg_target_i,
    output logic [31:0] next_pc_o,
    output logic        fault_o
);

    localparam logic [63:0] WIN_LO = 64'(RESET_PC);
    localparam logic [63:0] WIN_HI = WIN_LO + 64'(IM_WORDS) * 64'd4;

    logic [31:0] d_pc_plus4;
    logic [31:0] target;
    logic        misalign;
    logic        in_window;

    always_comb begin
        d_pc_plus4 = d_pc_i + 32'd4;
        target     = pc_i + 32'd4;
        misalign   = 1'b0;
        if (d_valid_i) begin
            case (npc_op_i)
                NPC_BR, NPC_CBL: begin
                    if (cmp_true_i) target = d_pc_plus4 + br_offset(imm16_i);
                end
                NPC_J: target = {d_pc_plus4[31:28], imm26_i, 2'b00};
                NPC_JR: begin
                    target   = reg_target_i;
                    misalign = |reg_target_i[1:0];
                end
                default: ;
            endcase
        end
        // A faulting PC is still loaded, so force it word-aligned here.
        next_pc_o = target & ~32'h3;
        in_window = (64'(next_pc_o) >= WIN_LO) && (64'(next_pc_o) < WIN_HI);
        fault_o   = misalign | ~in_window;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and F/D register: one-cycle fetch latency, delayed branches, no flush.
// stall freezes PC, the F/D register and the sticky fault flag.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        cmp_true,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] reg_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        d_valid,
    output logic        pc_fault
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic        d_valid_q, d_valid_d;
    logic        pc_fault_q, pc_fault_d;
    logic [31:0] next_pc;
    logic        npc_fault;

    npc_calc #(
        .RESET_PC (RESET_PC),
        .IM_WORDS (IM_WORDS)
    ) u_npc_calc (
        .pc_i         (pc_q),
        .d_pc_i       (d_pc_q),
        .d_valid_i    (d_valid_q),
        .npc_op_i     (npc_op),
        .cmp_true_i   (cmp_true),
        .imm16_i      (imm16),
        .imm26_i      (imm26),
        .reg_target_i (reg_target),
        .next_pc_o    (next_pc),
        .fault_o      (npc_fault)
    );

    always_comb begin
        pc_d       = pc_q;
        d_instr_d  = d_instr_q;
        d_pc_d     = d_pc_q;
        d_valid_d  = d_valid_q;
        pc_fault_d = pc_fault_q;
        if (!stall) begin
            pc_d       = next_pc;
            d_instr_d  = im_rdata;
            d_pc_d     = pc_q;
            d_valid_d  = 1'b1;
            pc_fault_d = pc_fault_q | npc_fault;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            d_instr_q  <= NOP;
            d_pc_q     <= 32'h0;
            d_valid_q  <= 1'b0;
            pc_fault_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            d_instr_q  <= d_instr_d;
            d_pc_q     <= d_pc_d;
            d_valid_q  <= d_valid_d;
            pc_fault_q <= pc_fault_d;
        end
    end

    assign im_addr  = pc_q;
    assign d_instr  = d_instr_q;
    assign d_pc     = d_pc_q;
    assign d_valid  = d_valid_q;
    assign pc_fault = pc_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors push expected F/D state, a monitor pops and compares.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic        cmp_true;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] reg_target;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        d_valid;
    logic        pc_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dpc;
        logic        dv;
        logic        f;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_op     (npc_op),
        .cmp_true   (cmp_true),
        .imm16      (imm16),
        .imm26      (imm26),
        .reg_target (reg_target),
        .im_addr    (im_addr),
        .im_rdata   (im_rdata),
        .d_instr    (d_instr),
        .d_pc       (d_pc),
        .d_valid    (d_valid),
        .pc_fault   (pc_fault)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign im_rdata = imem(im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compares on every falling edge, or immediately when an async check is requested.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("im_addr", im_addr, e.pc);
                chk("d_pc", d_pc, e.dpc);
                chk("d_instr", d_instr, e.dv ? imem(e.dpc) : NOP);
                chk("d_valid", {31'b0, d_valid}, {31'b0, e.dv});
                chk("pc_fault", {31'b0, pc_fault}, {31'b0, e.f});
            end
        end
    end

    task automatic step(input logic st, input logic [2:0] op, input logic cmp,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rt,
                        input logic [31:0] epc, input logic [31:0] edpc,
                        input logic edv, input logic ef);
        stall      = st;
        npc_op     = op;
        cmp_true   = cmp;
        imm16      = i16;
        imm26      = i26;
        reg_target = rt;
        exp_q.push_back('{epc, edpc, edv, ef});
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input logic [31:0] epc, input logic [31:0] edpc, input logic ef);
        step(1'b0, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, epc, edpc, 1'b1, ef);
    endtask

    // Reset pulse placed between clock edges and checked without any edge in between.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.push_back('{32'h3000, 32'h0, 1'b0, 1'b0});
        ->chk_ev;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; npc_op = NPC_SEQ; cmp_true = 1'b0;
        imm16 = 16'h0; imm26 = 26'h0; reg_target = 32'h0;
        exp_q.push_back('{32'h3000, 32'h0, 1'b0, 1'b0});
        #12 reset = 1'b1;

        seq(32'h3004, 32'h3000, 1'b0);
        seq(32'h3008, 32'h3004, 1'b0);
        seq(32'h300C, 32'h3008, 1'b0);
        seq(32'h3010, 32'h300C, 1'b0);

        // Not-taken beq at 0x3004.
        do_reset();
        seq(32'h3004, 32'h3000, 1'b0);
        seq(32'h3008, 32'h3004, 1'b0);
        step(1'b0, NPC_BR, 1'b0, 16'h0003, 26'h0, 32'h0, 32'h300C, 32'h3008, 1'b1, 1'b0);

        // Taken beq at 0x3004; the first edge after reset must ignore a faulting jr.
        do_reset();
        step(1'b0, NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3022, 32'h3004, 32'h3000, 1'b1, 1'b0);
        seq(32'h3008, 32'h3004, 1'b0);
        step(1'b0, NPC_BR, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h3014, 32'h3008, 1'b1, 1'b0);
        seq(32'h3018, 32'h3014, 1'b0);
        step(1'b0, NPC_CBL, 1'b1, 16'hFFFF, 26'h0, 32'h0, 32'h3014, 32'h3018, 1'b1, 1'b0);
        step(1'b0, 3'b101, 1'b1, 16'h0003, 26'h0, 32'h0, 32'h3018, 32'h3014, 1'b1, 1'b0);
        step(1'b0, NPC_CBL, 1'b0, 16'h0003, 26'h0, 32'h0, 32'h301C, 32'h3018, 1'b1, 1'b0);
        seq(32'h3020, 32'h301C, 1'b0);

        // jal held in D across a 3-cycle stall, then delay slot, then target.
        repeat (3) step(1'b1, NPC_J, 1'b0, 16'h0, 26'h0000C10, 32'h0, 32'h3020, 32'h301C, 1'b1, 1'b0);
        step(1'b0, NPC_J, 1'b0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 32'h3020, 1'b1, 1'b0);
        seq(32'h3044, 32'h3040, 1'b0);
        step(1'b0, NPC_J, 1'b0, 16'h0, 26'h0000C40, 32'h0, 32'h3100, 32'h3044, 1'b1, 1'b0);

        // Reset at pc=0x3100, then a misaligned jr sets the sticky fault.
        do_reset();
        step(1'b0, NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3022, 32'h3004, 32'h3000, 1'b1, 1'b0);
        step(1'b0, NPC_JR, 1'b0, 16'h0, 26'h0, 32'h3022, 32'h3020, 32'h3004, 1'b1, 1'b1);
        seq(32'h3024, 32'h3020, 1'b1);
        seq(32'h3028, 32'h3024, 1'b1);
        step(1'b1, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3028, 32'h3024, 1'b1, 1'b1);

        // Window boundary: last word is legal, sequential step past it faults, then PC wrap.
        do_reset();
        seq(32'h3004, 32'h3000, 1'b0);
        step(1'b0, NPC_JR, 1'b0, 16'h0, 26'h0, 32'h6FFC, 32'h6FFC, 32'h3004, 1'b1, 1'b0);
        seq(32'h7000, 32'h6FFC, 1'b1);
        step(1'b0, NPC_JR, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h7000, 1'b1, 1'b1);
        seq(32'h0000_0000, 32'hFFFF_FFFC, 1'b1);
        seq(32'h0000_0004, 32'h0000_0000, 1'b1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
